// File: rtl/error_metrics_acc.sv
// Approximate-arithmetic error-metric accumulator: counts error rate, ED sum/max and, with
// ERRMET_MRED_EN defined, the MRED numerator via a serial restoring divider.
module error_metrics_acc #(
  parameter int W      = 8,
  parameter int N_LOG2 = 16,
  parameter int FRAC   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               approx,
  input  logic [W-1:0]               exact,
  output logic                       busy,
  output logic                       done,
  output logic [N_LOG2:0]            err_count,
  output logic [W+N_LOG2-1:0]        ed_sum,
  output logic [W-1:0]               ed_max,
  output logic [W+FRAC+N_LOG2-1:0]   red_sum
);

  localparam int CW  = N_LOG2 + 1;
  localparam int ESW = W + N_LOG2;
  localparam int QW  = W + FRAC;
  localparam int RSW = W + FRAC + N_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

  state_t            state;
  logic [N_LOG2-1:0] cnt;
  logic [W-1:0]      ed;
  logic              fire;
  logic              last;

  assign ed   = (approx >= exact) ? (approx - exact) : (exact - approx);
  assign fire = in_valid && in_ready;
  assign last = (cnt == {N_LOG2{1'b1}});

`ifdef ERRMET_MRED_EN
  localparam int IW = $clog2(QW);

  logic [QW-1:0] dvd;
  logic [QW-1:0] quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [IW-1:0] iter;
  logic          last_pend;
  logic [W:0]    rem_sh;
  logic          ge;
  logic [W-1:0]  rem_nx;
  logic [QW-1:0] quo_nx;

  // Remainder stays below the divisor, so W bits hold it; one extra bit covers the shift-in.
  always_comb begin
    rem_sh = {rem, dvd[QW-1]};
    ge     = (rem_sh >= {1'b0, dvs});
    rem_nx = ge ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];
    quo_nx = {quo[QW-2:0], ge};
  end
`else
  assign red_sum = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      err_count <= '0;
      ed_sum    <= '0;
      ed_max    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
`ifdef ERRMET_MRED_EN
      red_sum   <= '0;
      dvd       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      iter      <= '0;
      last_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            cnt       <= '0;
            err_count <= '0;
            ed_sum    <= '0;
            ed_max    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef ERRMET_MRED_EN
            red_sum   <= '0;
`endif
          end
        end

        RUN: begin
          if (fire) begin
            cnt       <= cnt + N_LOG2'(1);
            err_count <= err_count + CW'(ed != '0);
            ed_sum    <= ed_sum + ESW'(ed);
            if (ed > ed_max) ed_max <= ed;
`ifdef ERRMET_MRED_EN
            // Zero-ED and zero-reference samples add nothing to red_sum, so they never stall.
            if (exact != '0 && ed != '0) begin
              state     <= DIV;
              in_ready  <= 1'b0;
              dvd       <= {ed, {FRAC{1'b0}}};
              dvs       <= exact;
              quo       <= '0;
              rem       <= '0;
              iter      <= '0;
              last_pend <= last;
            end else
`endif
            if (last) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end

`ifdef ERRMET_MRED_EN
        DIV: begin
          rem  <= rem_nx;
          quo  <= quo_nx;
          dvd  <= {dvd[QW-2:0], 1'b0};
          iter <= iter + IW'(1);
          if (iter == IW'(QW - 1)) begin
            red_sum <= red_sum + RSW'(quo_nx);
            if (last_pend) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_error_metrics_acc.sv
// Directed plus randomized bench for error_metrics_acc (W=8, N_LOG2=2, FRAC=16).
module tb_error_metrics_acc;
  localparam int W = 8;
  localparam int N_LOG2 = 2;
  localparam int FRAC = 16;
`ifdef ERRMET_MRED_EN
  localparam bit MRED = 1'b1;
`else
  localparam bit MRED = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic                     in_valid;
  logic                     in_ready;
  logic [W-1:0]             approx;
  logic [W-1:0]             exact;
  logic                     busy;
  logic                     done;
  logic [N_LOG2:0]          err_count;
  logic [W+N_LOG2-1:0]      ed_sum;
  logic [W-1:0]             ed_max;
  logic [W+FRAC+N_LOG2-1:0] red_sum;

  error_metrics_acc #(.W(W), .N_LOG2(N_LOG2), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .approx(approx), .exact(exact), .busy(busy), .done(done), .err_count(err_count),
    .ed_sum(ed_sum), .ed_max(ed_max), .red_sum(red_sum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int sa[4];
  int se[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference metrics over the first n samples of sa/se, straight from the metric definitions.
  task automatic model(input int n, output logic [63:0] er, output logic [63:0] es,
                       output logic [63:0] em, output logic [63:0] rs);
    er = 0; es = 0; em = 0; rs = 0;
    for (int i = 0; i < n; i++) begin
      longint d;
      d = (sa[i] > se[i]) ? sa[i] - se[i] : se[i] - sa[i];
      if (d != 0) er++;
      es += d;
      if (d > em) em = d;
      if (MRED && se[i] != 0) rs += (d * (64'd1 << FRAC)) / se[i];
    end
  endtask

  task automatic check_outs(input string tag, input int n);
    logic [63:0] er, es, em, rs;
    model(n, er, es, em, rs);
    check({tag, ".err_count"}, 64'(err_count), er);
    check({tag, ".ed_sum"},    64'(ed_sum), es);
    check({tag, ".ed_max"},    64'(ed_max), em);
    check({tag, ".red_sum"},   64'(red_sum), rs);
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Hand over one sample, then count cycles the block spends busy but not ready.
  task automatic send(input string tag, input int a, input int e);
    int w;
    int stall;
    int exp_stall;
    w = 0;
    approx = W'(a);
    exact = W'(e);
    in_valid = 1'b1;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (!in_ready) check({tag, ".ready_timeout"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    stall = 0;
    while (busy && !in_ready && stall < 200) begin
      tick();
      stall++;
    end
    exp_stall = (MRED && e != 0 && a != e) ? W + FRAC : 0;
    check({tag, ".stall"}, 64'(stall), 64'(exp_stall));
  endtask

  task automatic run_stream(input string tag);
    start_run();
    check({tag, ".ready_after_start"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) send($sformatf("%s.s%0d", tag, i), sa[i], se[i]);
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check_outs(tag, 4);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; approx = '0; exact = '0;
    tick();
    tick();
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd0);
    sa = '{0, 0, 0, 0}; se = '{0, 0, 0, 0};
    check_outs("reset", 0);
    rst_n = 1'b1;

    // Samples offered while idle must be ignored.
    approx = 8'd9; exact = 8'd1; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check("idle_valid.err_count", 64'(err_count), 64'd0);
    check("idle_valid.in_ready", 64'(in_ready), 64'd0);

    sa = '{3, 5, 0, 10}; se = '{3, 3, 4, 0};
    run_stream("basic");
    if (MRED) check("basic.red_sum_const", 64'(red_sum), 64'd109226);
    check("basic.ed_sum_const", 64'(ed_sum), 64'd16);
    repeat (3) tick();
    check("basic.hold_done", 64'(done), 64'd1);
    check_outs("basic.hold", 4);

    sa = '{255, 255, 255, 255}; se = '{0, 0, 0, 0};
    run_stream("fullscale");
    check("fullscale.ed_sum_const", 64'(ed_sum), 64'd1020);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        sa[i] = int'($urandom_range(0, 255));
        k = int'($urandom_range(0, 7));
        se[i] = (k == 0) ? 0 : (k == 1) ? sa[i] : int'($urandom_range(0, 255));
      end
      run_stream($sformatf("rand%0d", r));
    end

    sa = '{7, 1, 200, 9}; se = '{2, 1, 50, 9};
    start_run();
    send("gap.s0", sa[0], se[0]);
    send("gap.s1", sa[1], se[1]);
    repeat (10) tick();
    check("gap.busy", 64'(busy), 64'd1);
    check_outs("gap.mid", 2);
    send("gap.s2", sa[2], se[2]);
    send("gap.s3", sa[3], se[3]);
    check("gap.done", 64'(done), 64'd1);
    check_outs("gap.end", 4);

    sa = '{4, 6, 8, 1}; se = '{1, 6, 2, 3};
    start_run();
    send("restart.s0", sa[0], se[0]);
    start_run();
    check_outs("restart.ignored", 1);
    send("restart.s1", sa[1], se[1]);
    send("restart.s2", sa[2], se[2]);
    send("restart.s3", sa[3], se[3]);
    check("restart.done", 64'(done), 64'd1);
    check_outs("restart.end", 4);
    start_run();
    check("restart2.done", 64'(done), 64'd0);
    check("restart2.busy", 64'(busy), 64'd1);
    check("restart2.in_ready", 64'(in_ready), 64'd1);
    sa = '{0, 0, 0, 0}; se = '{0, 0, 0, 0};
    check_outs("restart2.cleared", 0);
    sa = '{12, 0, 3, 90}; se = '{3, 0, 0, 45};
    for (int i = 0; i < 4; i++) send($sformatf("restart2.s%0d", i), sa[i], se[i]);
    check("restart2.end_done", 64'(done), 64'd1);
    check_outs("restart2.end", 4);

    // Reset while a division is in flight.
    start_run();
    approx = 8'd5; exact = 8'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("divreset.busy", 64'(busy), 64'd0);
    check("divreset.done", 64'(done), 64'd0);
    check("divreset.in_ready", 64'(in_ready), 64'd0);
    sa = '{0, 0, 0, 0}; se = '{0, 0, 0, 0};
    check_outs("divreset", 0);
    repeat (40) tick();
    check("divreset.late_red_sum", 64'(red_sum), 64'd0);
    check("divreset.late_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/error_metrics_acc.md
ERROR_METRICS_ACC -- requirements
Module: error_metrics_acc

Interface
REQ-001 SHALL have parameter W, default 8, meaning the width of the approximate and exact result operands.
REQ-002 SHALL have parameter N_LOG2, default 16, meaning log2 of the number of samples per run.
REQ-003 SHALL have parameter FRAC, default 16, meaning the fraction bits of each relative-error quotient.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins a run.
REQ-007 SHALL have port in_valid, input, 1 bit: approx and exact hold a sample.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-009 SHALL have port approx, input, W bits: approximate unit output.
REQ-010 SHALL have port exact, input, W bits: reference output.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN or DIV.
REQ-012 SHALL have port done, output, 1 bit: high in DONE.
REQ-013 SHALL have port err_count, output, N_LOG2+1 bits: number of samples with approx != exact.
REQ-014 SHALL have port ed_sum, output, W+N_LOG2 bits: sum of |approx-exact| (the NMED numerator).
REQ-015 SHALL have port ed_max, output, W bits: maximum |approx-exact| seen (EDmax).
REQ-016 SHALL have port red_sum, output, W+FRAC+N_LOG2 bits: sum of floor((ed<<FRAC)/exact) (the MRED numerator).

Function
REQ-017 SHALL implement states IDLE, RUN, DIV, DONE: IDLE/DONE -(start)-> RUN; RUN -(handshake needing division)-> DIV; DIV -(W+FRAC iterations complete)-> RUN, or DONE if it was the last sample; RUN -(last sample accepted, no division)-> DONE.
REQ-018 SHALL drive in_ready=1 only in RUN; a handshake is in_valid && in_ready.
REQ-019 SHALL, on start in IDLE or DONE, clear all accumulators and the sample counter on that edge and drive in_ready=1 the following cycle.
REQ-020 SHALL ignore start in RUN or DIV.
REQ-021 SHALL compute ed=|approx-exact| unsigned, full W bits, no wrap.
REQ-022 SHALL update err_count, ed_sum and ed_max on the edge that completes the handshake, so the new values are visible the next cycle.
REQ-023 SHALL end the run after exactly 2^N_LOG2 handshakes; err_count SHALL be able to hold 2^N_LOG2 and no accumulator SHALL overflow at full-scale input.
REQ-024 SHALL enter DIV only when exact != 0 and ed != 0; exact == 0 samples SHALL contribute nothing to red_sum, and ed == 0 samples SHALL contribute 0 with no stall.
REQ-025 SHALL use a restoring divider in DIV, one quotient bit per cycle for W+FRAC cycles; the truncated quotient SHALL be added to red_sum on the final DIV cycle.
REQ-026 SHALL hold all outputs stable in DONE until the next start.
REQ-027 SHALL treat in_valid outside RUN as a no-op with no stored samples.

Reset
REQ-028 SHALL, on rst_n=0 at a clock edge in any state (including mid-RUN or mid-DIV), enter IDLE, abort any division and clear err_count, ed_sum, ed_max, red_sum, the sample counter, busy, done and in_ready to 0.

Configuration
REQ-029 SHALL include the DIV state, the divider and red_sum accumulation only when ERRMET_MRED_EN is defined; without it, the DIV state and divider SHALL be absent, red_sum SHALL be tied to 0, and in_ready SHALL stay 1 for the whole of RUN.

Verification
REQ-030 SHALL verify, with W=8, N_LOG2=2, FRAC=16 and macro defined, that start plus samples (3,3), (5,3), (0,4), (10,0) gives done with err_count=3, ed_sum=16, ed_max=10 and red_sum=109226, and that in_ready drops for 24 cycles after samples 2 and 3 only.
REQ-031 SHALL verify that the same stream with the macro undefined gives identical err_count, ed_sum and ed_max, red_sum=0, in_ready continuously 1, and done asserted the cycle after the 4th handshake.
REQ-032 SHALL verify that four samples (255,0) give err_count=4, ed_sum=1020, ed_max=255 and red_sum=0.
REQ-033 SHALL verify that in_valid held low for 10 cycles mid-run leaves accumulators unchanged and busy=1, and that the run then completes normally.
REQ-034 SHALL verify that start pulsed in RUN is ignored and that start in DONE clears all outputs to 0 and begins a new run.
REQ-035 SHALL verify that rst_n=0 during DIV gives IDLE with all outputs 0 on the next cycle and no red_sum update afterwards.
